// File: rtl/au_norm_pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au_norm_pipe_pkg : shared helpers for the normalizer pipeline    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package au_norm_pipe_pkg;

   // Widest one-hot vector the encoder helper accepts.
   localparam int c_max_w = 256;

   function automatic int shift_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   function automatic int onehot_to_bin(input logic [c_max_w-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < c_max_w; i++) begin
         if (oh[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/au_norm_pipe_lead_one_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au_lead_one_det : one-hot marker of the most significant '1'     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module au_lead_one_det #(
   parameter int WIDTH = 16,
   parameter int ARCH  = 0
) (
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] z,
   output logic             no_det
);

   generate
      if (ARCH == 0) begin : g_scan
         // Ascending scan: the last set bit seen is the leading one.
         always_comb begin
            z = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (data[i]) begin
                  z    = '0;
                  z[i] = 1'b1;
               end
            end
         end
      end else begin : g_prefix
         assign z[WIDTH-1] = data[WIDTH-1];
         for (genvar i = 0; i < WIDTH-1; i++) begin : g_bit
            assign z[i] = data[i] & ~(|data[WIDTH-1:i+1]);
         end
      end
   endgenerate

   assign no_det = ~|data;

endmodule
`default_nettype wire

// File: rtl/au_norm_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au_norm_pipe : two-stage valid/ready left normalizer             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module au_norm_pipe
   import au_norm_pipe_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int ARCH  = 0,
   localparam int SW    = shift_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SW-1:0]    out_shift,
   output logic             out_zero
);

   logic [WIDTH-1:0]   w_z;
   logic               w_no_det;
   logic [c_max_w-1:0] w_oh_ext;
   logic [SW-1:0]      w_idx;
   logic [SW-1:0]      w_shift;
   logic               w_s2_free;
   logic               w_accept;
   logic               w_move;
   logic [WIDTH-1:0]   w_shifted;

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_word;
   logic [SW-1:0]      r_s1_shift;
   logic               r_s1_zero;

   au_lead_one_det #(
      .WIDTH (WIDTH),
      .ARCH  (ARCH)
   ) u_lod (
      .data   (in_data),
      .z      (w_z),
      .no_det (w_no_det)
   );

   always_comb begin
      w_oh_ext            = '0;
      w_oh_ext[WIDTH-1:0] = w_z;
   end

   assign w_idx   = SW'(onehot_to_bin(w_oh_ext));
   assign w_shift = w_no_det ? '0 : (SW'(WIDTH-1) - w_idx);

   // Ready chain: a word may enter whenever the slot ahead drains this cycle.
   assign w_s2_free = !out_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s2_free;
   assign w_accept  = in_valid && in_ready;
   assign w_move    = r_s1_valid && w_s2_free;

   assign w_shifted = r_s1_word << r_s1_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_word  <= '0;
         r_s1_shift <= '0;
         r_s1_zero  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_word  <= in_data;
            r_s1_shift <= w_shift;
            r_s1_zero  <= w_no_det;
         end else if (w_move) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_shift <= '0;
         out_zero  <= 1'b0;
      end else begin
         if (w_move) begin
            out_valid <= 1'b1;
            out_data  <= w_shifted;
            out_shift <= r_s1_shift;
            out_zero  <= r_s1_zero;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_au_norm_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_au_norm_pipe : self-checking bench, clz+shift reference model |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_au_norm_pipe;

   localparam int W1  = 16;
   localparam int W2  = 33;
   localparam int SW1 = $clog2(W1);
   localparam int SW2 = $clog2(W2);

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           out_ready;
   logic [W1-1:0]  d1;
   logic [W2-1:0]  d2;

   logic           ir1, ov1, oz1;
   logic [W1-1:0]  od1;
   logic [SW1-1:0] os1;
   logic           ir2, ov2, oz2;
   logic [W2-1:0]  od2;
   logic [SW2-1:0] os2;

   int      checks = 0;
   int      errors = 0;
   longint  n_in   = 0;
   longint  n_out  = 0;
   longint  n_drop = 0;

   // Words in flight, oldest first; vis means the oldest sits on the outputs.
   logic [63:0] q1[$];
   logic [63:0] q2[$];
   bit          vis = 1'b0;

   always #5 clk = ~clk;

   au_norm_pipe #(.WIDTH(W1), .ARCH(0)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir1),
      .in_data   (d1),
      .out_valid (ov1),
      .out_ready (out_ready),
      .out_data  (od1),
      .out_shift (os1),
      .out_zero  (oz1)
   );

   au_norm_pipe #(.WIDTH(W2), .ARCH(1)) u_dut33 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir2),
      .in_data   (d2),
      .out_valid (ov2),
      .out_ready (out_ready),
      .out_data  (od2),
      .out_shift (os2),
      .out_zero  (oz2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mask(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

   function automatic int clz(input logic [63:0] w, input int width);
      for (int i = width - 1; i >= 0; i--) begin
         if (w[i]) return width - 1 - i;
      end
      return 0;
   endfunction

   function automatic logic [63:0] norm(input logic [63:0] w, input int width);
      return (w << clz(w, width)) & mask(width);
   endfunction

   function automatic logic [63:0] rnd(input int width);
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       v = '0;
         1:       v = 64'd1 << $urandom_range(0, width - 1);
         2:       v = v;
         default: v = v >> $urandom_range(0, 63);
      endcase
      return v & mask(width);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: advance the in-flight queue on every active edge.
   initial begin
      bit acc;
      bit pop;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            n_drop += q1.size();
            q1.delete();
            q2.delete();
            vis = 1'b0;
         end else begin
            acc = in_valid && (q1.size() < 2 || out_ready);
            pop = vis && out_ready;
            if (pop) begin
               void'(q1.pop_front());
               void'(q2.pop_front());
               n_out++;
            end
            vis = (q1.size() > 0);
            if (acc) begin
               q1.push_back(64'(d1));
               q2.push_back(64'(d2));
               n_in++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("in_ready16", 64'(ir1), 64'(q1.size() < 2 || out_ready));
            chk("in_ready33", 64'(ir2), 64'(q2.size() < 2 || out_ready));
            chk("out_valid16", 64'(ov1), 64'(vis));
            chk("out_valid33", 64'(ov2), 64'(vis));
            if (vis) begin
               chk("data16",  64'(od1), norm(q1[0], W1));
               chk("shift16", 64'(os1), 64'(clz(q1[0], W1)));
               chk("zero16",  64'(oz1), 64'(q1[0] == 0));
               chk("data33",  64'(od2), norm(q2[0], W2));
               chk("shift33", 64'(os2), 64'(clz(q2[0], W2)));
               chk("zero33",  64'(oz2), 64'(q2[0] == 0));
            end
         end
      end
   end

   task automatic single(input logic [15:0] w, input logic [15:0] e_d, input int e_s,
                         input bit e_z, input logic [32:0] e_d2, input int e_s2);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      d1        = w;
      d2        = W2'(w);
      tick();
      in_valid  = 1'b0;
      tick();
      chk("lit_valid16", 64'(ov1), 64'd1);
      chk("lit_data16",  64'(od1), 64'(e_d));
      chk("lit_shift16", 64'(os1), 64'(e_s));
      chk("lit_zero16",  64'(oz1), 64'(e_z));
      chk("lit_data33",  64'(od2), 64'(e_d2));
      chk("lit_shift33", 64'(os2), 64'(e_s2));
      tick();
   endtask

   initial begin
      logic [15:0] b2b [4];
      longint      n_start;
      int          cyc;
      b2b = '{16'h0003, 16'h4000, 16'h0000, 16'h0100};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d1        = '0;
      d2        = '0;
      repeat (3) tick();
      chk("rst_out_valid16", 64'(ov1), 64'd0);
      chk("rst_out_valid33", 64'(ov2), 64'd0);
      chk("rst_in_ready",    64'(ir1), 64'd1);
      chk("rst_out_data",    64'(od1), 64'd0);
      chk("rst_out_shift",   64'(os1), 64'd0);
      chk("rst_out_zero",    64'(oz1), 64'd0);
      rst_n = 1'b1;
      tick();

      single(16'h0001, 16'h8000, 15, 1'b0, 33'h1_0000_0000, 32);
      single(16'h8000, 16'h8000, 0,  1'b0, 33'h1_0000_0000, 17);
      single(16'h0000, 16'h0000, 0,  1'b1, 33'h0,           0);
      single(16'h00F3, 16'hF300, 8,  1'b0, 33'h1_E600_0000, 25);
      tick();

      // Back-to-back stream with the sink always ready.
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         d1       = b2b[k];
         d2       = W2'(b2b[k]);
         chk("b2b_in_ready", 64'(ir1), 64'd1);
         tick();
         if (k >= 1) chk("b2b_out_valid", 64'(ov1), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_out_valid_last", 64'(ov1), 64'd1);
      chk("b2b_last_data", 64'(od1), 64'h8000);
      tick();
      chk("b2b_out_idle", 64'(ov1), 64'd0);

      // Stall: two words fill the pipe, the third is held off.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d1 = 16'h0001; d2 = W2'(16'h0001);
      tick();
      d1 = 16'h0F00; d2 = W2'(16'h0F00);
      tick();
      d1 = 16'h0000; d2 = W2'(16'h0000);
      chk("stall_in_ready", 64'(ir1), 64'd0);
      chk("stall_data_a",   64'(od1), 64'h8000);
      tick();
      chk("stall_hold_ready", 64'(ir1), 64'd0);
      chk("stall_hold_data",  64'(od1), 64'h8000);
      chk("stall_hold_shift", 64'(os1), 64'd15);
      tick();
      chk("stall_hold_valid", 64'(ov1), 64'd1);
      chk("stall_hold_data2", 64'(od1), 64'h8000);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("stall_rel_b_data",  64'(od1), 64'hF000);
      chk("stall_rel_b_shift", 64'(os1), 64'd4);
      tick();
      chk("stall_rel_c_zero", 64'(oz1), 64'd1);
      chk("stall_rel_c_data", 64'(od1), 64'd0);
      tick();
      chk("stall_drained", 64'(ov1), 64'd0);

      // Asynchronous reset with two words buffered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d1 = 16'h1234; d2 = W2'(16'h1234);
      tick();
      d1 = 16'h0042; d2 = W2'(16'h0042);
      tick();
      in_valid = 1'b0;
      chk("rst_mid_full", 64'(ov1), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_async16", 64'(ov1), 64'd0);
      chk("rst_mid_async33", 64'(ov2), 64'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rst_mid_nothing", 64'(ov1 | ov2), 64'd0);
      end

      // Random traffic.
      n_start = n_in;
      cyc     = 0;
      while (n_in < n_start + 10000 && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         d1        = W1'(rnd(W1));
         d2        = W2'(rnd(W2));
         tick();
         cyc++;
      end
      chk("random_words_done", 64'(n_in - n_start >= 10000), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("drain_empty", 64'(q1.size()), 64'd0);
      chk("count_in_eq_out", 64'(n_in), 64'(n_out + n_drop));
      chk("drain_out_valid", 64'(ov1 | ov2), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
